aes128_arbiter: RTL and testbench
=================================

AES128_ARBITER -- requirements
Module: aes128_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32: max cycles in KEY_WAIT or DATA_WAIT before error.
REQ-002 clk_i  in  1  single clock; all logic on rising edge.
REQ-003 rst_ni  in  1  reset, synchronous, active-low.
REQ-004 req_valid_i  in  2  per-requester request valid (bit i = requester i).
REQ-005 req_ready_o  out  2  per-requester accept; one-cycle pulse on capture.
REQ-006 req_enc_i  in  2  per-requester mode: 1 encrypt, 0 decrypt.
REQ-007 req_key_i  in  256  requester i key at bits [128*i+127:128*i].
REQ-008 req_data_i  in  256  requester i plain/cipher text, same packing.
REQ-009 resp_valid_o  out  1  result valid; held until accepted.
REQ-010 resp_ready_i  in  1  result accept.
REQ-011 resp_id_o  out  1  requester index owning the result.
REQ-012 resp_data_o  out  128  result text.
REQ-013 resp_err_o  out  1  timeout flag for this result.
REQ-014 aes_reset_key_o, aes_load_data_o  out  1 each  one-cycle pulses to the core.
REQ-015 aes_enc_or_dec_o  out  1; aes_cipher_key_o, aes_plain_text_o  out  128 each  core operands.
REQ-016 aes_key_ready_i, aes_cipher_ready_i  in  1 each; aes_cipher_text_i  in  128  core status/result.

Function
REQ-017 FSM states: IDLE, KEY_LOAD, KEY_WAIT, DATA_LOAD, DATA_WAIT, RESP.
REQ-018 IDLE: if any req_valid_i, grant one, pulse its req_ready_o in the same cycle, capture its enc/key/data and index.
REQ-019 Arbitration: round-robin; both valid -> grant the requester not granted last; last_grant resets to 1 (requester 0 wins first tie).
REQ-020 After capture: key_cached set and captured key equal to cached key -> DATA_LOAD; else -> KEY_LOAD.
REQ-021 KEY_LOAD (1 cycle): aes_reset_key_o=1, aes_cipher_key_o=captured key; -> KEY_WAIT.
REQ-022 KEY_WAIT: aes_key_ready_i=1 -> store cached key, set key_cached, -> DATA_LOAD.
REQ-023 DATA_LOAD (1 cycle): aes_load_data_o=1, aes_plain_text_o=captured data; -> DATA_WAIT.
REQ-024 DATA_WAIT: aes_cipher_ready_i=1 -> register aes_cipher_text_i into resp_data_o, resp_err_o=0, -> RESP.
REQ-025 aes_enc_or_dec_o driven from captured mode, constant from DATA_LOAD until RESP entry.
REQ-026 Core status is never sampled in the cycle a load pulse is driven; first sample is the following cycle.
REQ-027 Watchdog: counter cleared on entry to KEY_WAIT/DATA_WAIT; reaching TIMEOUT_CYCLES -> RESP with resp_err_o=1, resp_data_o=0, key_cached cleared.
REQ-028 RESP: resp_valid_o=1, id/data/err stable; resp_ready_i=1 -> IDLE, update last_grant. No new grant in that cycle.
REQ-029 Request inputs ignored outside IDLE; req_ready_o=0 outside IDLE.
REQ-030 Throughput: one operation in flight; cached-key encrypt = 1 capture + 1 load + core latency + response handshake.

Reset
REQ-031 rst_ni=0 at any state, including mid-operation -> IDLE, all outputs 0, key_cached=0, watchdog=0, last_grant=1.
REQ-032 The core has no reset input; after reset the first request always reloads the key.

Structure
REQ-033 Shared package holds FSM state enum, AES block width 128, requester count 2, watchdog counter width.
REQ-034 Single sub-module: rr_arbiter2 (2-way round-robin grant with last_grant register); core instantiated outside this block.

Verification
REQ-035 Req0 enc, key 000102..0f, data 00112233..eeff -> one aes_reset_key_o, one aes_load_data_o, resp_data 69c4e0d8..c55a, id 0, err 0.
REQ-036 Second req0 same key, decrypt 69c4e0d8..c55a -> no aes_reset_key_o, resp_data 00112233..eeff.
REQ-037 Both valid in same cycle, distinct keys -> grants 0 then 1 then 0; each key change issues aes_reset_key_o.
REQ-038 Core model never raises aes_cipher_ready_i -> resp_err_o=1, resp_data_o=0 after 32 cycles in DATA_WAIT; next request reloads key.
REQ-039 rst_ni low during DATA_WAIT -> next cycle IDLE, all outputs 0; following same-key request issues aes_reset_key_o.
REQ-040 resp_ready_i held low 5 cycles -> resp_valid/data/id stable; req_ready_o stays 0 throughout.

Source files
------------

// File: rtl/aes128_arbiter_pkg.sv
// Shared types and sizes for the two-requester AES-128 front-end arbiter.
package aes128_arbiter_pkg;
    localparam int AES_W   = 128;
    localparam int NUM_REQ = 2;
    localparam int WD_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_KEY_LOAD  = 3'd1,
        ST_KEY_WAIT  = 3'd2,
        ST_DATA_LOAD = 3'd3,
        ST_DATA_WAIT = 3'd4,
        ST_RESP      = 3'd5
    } state_t;
endpackage

// File: rtl/aes128_arbiter_if.sv
// Requester, response and AES-core signals bundled between the arbiter and its environment.
interface aes128_arbiter_if;
    import aes128_arbiter_pkg::*;

    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [NUM_REQ-1:0]       req_enc_i;
    logic [NUM_REQ*AES_W-1:0] req_key_i;
    logic [NUM_REQ*AES_W-1:0] req_data_i;
    logic                     resp_valid_o;
    logic                     resp_ready_i;
    logic                     resp_id_o;
    logic [AES_W-1:0]         resp_data_o;
    logic                     resp_err_o;
    logic                     aes_reset_key_o;
    logic                     aes_load_data_o;
    logic                     aes_enc_or_dec_o;
    logic [AES_W-1:0]         aes_cipher_key_o;
    logic [AES_W-1:0]         aes_plain_text_o;
    logic                     aes_key_ready_i;
    logic                     aes_cipher_ready_i;
    logic [AES_W-1:0]         aes_cipher_text_i;

    modport slave (
        input  req_valid_i, req_enc_i, req_key_i, req_data_i, resp_ready_i,
        input  aes_key_ready_i, aes_cipher_ready_i, aes_cipher_text_i,
        output req_ready_o, resp_valid_o, resp_id_o, resp_data_o, resp_err_o,
        output aes_reset_key_o, aes_load_data_o, aes_enc_or_dec_o,
        output aes_cipher_key_o, aes_plain_text_o
    );

    modport master (
        output req_valid_i, req_enc_i, req_key_i, req_data_i, resp_ready_i,
        output aes_key_ready_i, aes_cipher_ready_i, aes_cipher_text_i,
        input  req_ready_o, resp_valid_o, resp_id_o, resp_data_o, resp_err_o,
        input  aes_reset_key_o, aes_load_data_o, aes_enc_or_dec_o,
        input  aes_cipher_key_o, aes_plain_text_o
    );
endinterface

// File: rtl/aes128_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the last-served index is updated only when a result is retired.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic       i_update_id,
    output logic [1:0] o_grant,
    output logic       o_grant_id,
    output logic       o_grant_valid
);
    logic r_last_grant;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_last_grant <= 1'b1;
        end else if (i_update) begin
            r_last_grant <= i_update_id;
        end
    end

    // On a tie, serve whoever was not served last.
    always_comb begin
        o_grant_valid = |i_req;
        o_grant_id    = (i_req == 2'b11) ? ~r_last_grant : i_req[1];
        o_grant       = o_grant_valid ? (o_grant_id ? 2'b10 : 2'b01) : 2'b00;
    end
endmodule

// File: rtl/aes128_arbiter.sv
// Shares one AES-128 core between two requesters, caching the last expanded key to skip reloads.
module aes128_arbiter
    import aes128_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32  // must fit in WD_W bits
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    aes128_arbiter_if.slave  bus
);
    state_t             r_state;
    logic               r_id;
    logic               r_enc;
    logic [AES_W-1:0]   r_key;
    logic [AES_W-1:0]   r_data;
    logic [AES_W-1:0]   r_cached_key;
    logic               r_key_cached;
    logic [WD_W-1:0]    r_wd;
    logic               r_resp_valid;
    logic [AES_W-1:0]   r_resp_data;
    logic               r_resp_err;
    logic               r_aes_reset_key;
    logic               r_aes_load_data;
    logic               r_aes_enc;
    logic [AES_W-1:0]   r_aes_key;
    logic [AES_W-1:0]   r_aes_text;

    logic [AES_W-1:0]   w_req_key  [NUM_REQ];
    logic [AES_W-1:0]   w_req_data [NUM_REQ];
    logic [NUM_REQ-1:0] w_grant;
    logic               w_grant_id;
    logic               w_grant_valid;
    logic               w_idle;
    logic               w_key_hit;
    logic               w_wd_expired;
    logic               w_rr_update;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_req_key[gi]  = bus.req_key_i[gi*AES_W +: AES_W];
            assign w_req_data[gi] = bus.req_data_i[gi*AES_W +: AES_W];
        end
    endgenerate

    assign w_idle       = (r_state == ST_IDLE);
    assign w_key_hit    = r_key_cached && (w_req_key[w_grant_id] == r_cached_key);
    assign w_wd_expired = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
    assign w_rr_update  = (r_state == ST_RESP) && bus.resp_ready_i;

    rr_arbiter2 u_rr (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .i_req         (bus.req_valid_i),
        .i_update      (w_rr_update),
        .i_update_id   (r_id),
        .o_grant       (w_grant),
        .o_grant_id    (w_grant_id),
        .o_grant_valid (w_grant_valid)
    );

    // Accept is combinational so the requester sees it in the capture cycle itself.
    assign bus.req_ready_o      = w_grant & {NUM_REQ{w_idle & rst_ni}};
    assign bus.resp_valid_o     = r_resp_valid;
    assign bus.resp_id_o        = r_id;
    assign bus.resp_data_o      = r_resp_data;
    assign bus.resp_err_o       = r_resp_err;
    assign bus.aes_reset_key_o  = r_aes_reset_key;
    assign bus.aes_load_data_o  = r_aes_load_data;
    assign bus.aes_enc_or_dec_o = r_aes_enc;
    assign bus.aes_cipher_key_o = r_aes_key;
    assign bus.aes_plain_text_o = r_aes_text;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state         <= ST_IDLE;
            r_id            <= 1'b0;
            r_enc           <= 1'b0;
            r_key           <= '0;
            r_data          <= '0;
            r_cached_key    <= '0;
            r_key_cached    <= 1'b0;
            r_wd            <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_data     <= '0;
            r_resp_err      <= 1'b0;
            r_aes_reset_key <= 1'b0;
            r_aes_load_data <= 1'b0;
            r_aes_enc       <= 1'b0;
            r_aes_key       <= '0;
            r_aes_text      <= '0;
        end else begin
            r_aes_reset_key <= 1'b0;
            r_aes_load_data <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_id   <= w_grant_id;
                        r_enc  <= bus.req_enc_i[w_grant_id];
                        r_key  <= w_req_key[w_grant_id];
                        r_data <= w_req_data[w_grant_id];
                        if (w_key_hit) begin
                            r_aes_load_data <= 1'b1;
                            r_aes_text      <= w_req_data[w_grant_id];
                            r_aes_enc       <= bus.req_enc_i[w_grant_id];
                            r_state         <= ST_DATA_LOAD;
                        end else begin
                            r_aes_reset_key <= 1'b1;
                            r_aes_key       <= w_req_key[w_grant_id];
                            r_state         <= ST_KEY_LOAD;
                        end
                    end
                end
                ST_KEY_LOAD: begin
                    r_wd    <= '0;
                    r_state <= ST_KEY_WAIT;
                end
                ST_DATA_LOAD: begin
                    r_wd    <= '0;
                    r_state <= ST_DATA_WAIT;
                end
                ST_KEY_WAIT, ST_DATA_WAIT: begin
                    if (r_state == ST_KEY_WAIT && bus.aes_key_ready_i) begin
                        r_cached_key    <= r_key;
                        r_key_cached    <= 1'b1;
                        r_aes_load_data <= 1'b1;
                        r_aes_text      <= r_data;
                        r_aes_enc       <= r_enc;
                        r_state         <= ST_DATA_LOAD;
                    end else if (r_state == ST_DATA_WAIT && bus.aes_cipher_ready_i) begin
                        r_resp_data  <= bus.aes_cipher_text_i;
                        r_resp_err   <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end else if (w_wd_expired) begin
                        // Core state is unknown after a stall, so force a key reload next time.
                        r_resp_data  <= '0;
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_key_cached <= 1'b0;
                        r_state      <= ST_RESP;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready_i) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes128_arbiter.sv
// Scoreboard bench for aes128_arbiter with a behavioural AES-core stand-in.
module tb_aes128_arbiter;
    import aes128_arbiter_pkg::*;

    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2 = 128'hfedcba98765432100123456789abcdef;

    typedef struct packed {
        logic         id;
        logic [127:0] data;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes128_arbiter_if bus();

    aes128_arbiter #(.TIMEOUT_CYCLES(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   cyc = 0, n_rkey = 0, n_load = 0, t_load = 0, t_resp = 0;
    logic ack_en = 1'b1;
    logic prev_rv = 1'b0;

    // Reference core behaviour: real FIPS-197 vector for K0, a keyed mix otherwise.
    function automatic logic [127:0] core_f(input logic [127:0] k, input logic e, input logic [127:0] d);
        if (k == K0 && e && d == PT) return CT;
        if (k == K0 && !e && d == CT) return PT;
        return e ? (d ^ k) : ({d[63:0], d[127:64]} ^ k);
    endfunction

    logic         hang = 1'b0;
    logic         m_key_ready = 1'b0, m_cipher_ready = 1'b0, m_enc = 1'b0;
    logic [127:0] m_key = '0, m_data = '0, m_text = '0;
    int           kcnt = 0, ccnt = 0;

    assign bus.aes_key_ready_i    = m_key_ready;
    assign bus.aes_cipher_ready_i = m_cipher_ready;
    assign bus.aes_cipher_text_i  = m_text;

    always @(posedge clk) begin
        if (bus.aes_reset_key_o) begin
            m_key <= bus.aes_cipher_key_o; m_key_ready <= 1'b0; kcnt <= 3;
        end else if (kcnt != 0) begin
            kcnt <= kcnt - 1;
            if (kcnt == 1) m_key_ready <= 1'b1;
        end
        if (bus.aes_load_data_o) begin
            m_data <= bus.aes_plain_text_o; m_enc <= bus.aes_enc_or_dec_o;
            m_cipher_ready <= 1'b0; ccnt <= 5;
        end else if (ccnt != 0) begin
            ccnt <= ccnt - 1;
            if (ccnt == 1 && !hang) begin
                m_cipher_ready <= 1'b1;
                m_text <= core_f(m_key, m_enc, m_data);
            end
        end
    end

    // Response side: counts core pulses and retires results against the scoreboard.
    initial begin
        exp_t e;
        bus.resp_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.aes_reset_key_o) n_rkey++;
            if (bus.aes_load_data_o) begin n_load++; t_load = cyc; end
            if (bus.resp_valid_o && !prev_rv) t_resp = cyc;
            prev_rv = bus.resp_valid_o;
            if (bus.resp_valid_o && ack_en) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected got id=%0d data=%h err=%0d required none",
                             bus.resp_id_o, bus.resp_data_o, bus.resp_err_o);
                end else begin
                    e = sb.pop_front();
                    if (bus.resp_id_o !== e.id || bus.resp_data_o !== e.data || bus.resp_err_o !== e.err) begin
                        errors++;
                        $display("FAIL resp got id=%0d data=%h err=%0d required id=%0d data=%h err=%0d",
                                 bus.resp_id_o, bus.resp_data_o, bus.resp_err_o, e.id, e.data, e.err);
                    end else begin
                        $display("resp id=%0d data=%h err=%0d ok", bus.resp_id_o, bus.resp_data_o, bus.resp_err_o);
                    end
                end
                bus.resp_ready_i = 1'b1;
            end else begin
                bus.resp_ready_i = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic do_req(input logic id, input logic enc, input logic [127:0] key,
                          input logic [127:0] data, input logic exp_err, input logic push);
        logic got;
        exp_t e;
        @(negedge clk);
        bus.req_enc_i[id] = enc;
        bus.req_key_i[int'(id)*128 +: 128]  = key;
        bus.req_data_i[int'(id)*128 +: 128] = data;
        bus.req_valid_i[id] = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            #1;
            if (bus.req_ready_o[id]) got = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL grant_timeout req%0d got no req_ready required req_ready", id);
            bus.req_valid_i[id] = 1'b0;
        end else begin
            e.id = id; e.err = exp_err;
            e.data = exp_err ? 128'h0 : core_f(key, enc, data);
            if (push) sb.push_back(e);
            $display("req id=%0d enc=%0d key=%h data=%h", id, enc, key, data);
            @(posedge clk);
            #1 bus.req_valid_i[id] = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk); #1;
            if (sb.size() == 0 && !bus.resp_valid_o) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_%s pending=%0d required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid_i = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.req_ready_o !== 2'b00) begin
            errors++; $display("FAIL reset_req_ready got %b required 00", bus.req_ready_o);
        end
        checks++;
        if ({bus.resp_valid_o, bus.resp_id_o, bus.resp_err_o} !== 3'b000 || bus.resp_data_o !== 128'h0) begin
            errors++; $display("FAIL reset_resp got v=%0d id=%0d err=%0d data=%h required zeros",
                               bus.resp_valid_o, bus.resp_id_o, bus.resp_err_o, bus.resp_data_o);
        end
        checks++;
        if ({bus.aes_reset_key_o, bus.aes_load_data_o, bus.aes_enc_or_dec_o} !== 3'b000) begin
            errors++; $display("FAIL reset_aes_ctrl got %b required 000",
                               {bus.aes_reset_key_o, bus.aes_load_data_o, bus.aes_enc_or_dec_o});
        end
        checks++;
        if (bus.aes_cipher_key_o !== 128'h0 || bus.aes_plain_text_o !== 128'h0) begin
            errors++; $display("FAIL reset_aes_data got key=%h text=%h required zeros",
                               bus.aes_cipher_key_o, bus.aes_plain_text_o);
        end
        bus.req_valid_i = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic test_encrypt();
        int k0, l0;
        k0 = n_rkey; l0 = n_load;
        do_req(1'b0, 1'b1, K0, PT, 1'b0, 1'b1);
        wait_drain("encrypt");
        checks++;
        if (n_rkey - k0 != 1 || n_load - l0 != 1) begin
            errors++; $display("FAIL encrypt_pulses got rkey=%0d load=%0d required 1 1", n_rkey - k0, n_load - l0);
        end
    endtask

    task automatic test_cached_decrypt();
        int k0, l0;
        k0 = n_rkey; l0 = n_load;
        do_req(1'b0, 1'b0, K0, CT, 1'b0, 1'b1);
        wait_drain("cached");
        checks++;
        if (n_rkey - k0 != 0 || n_load - l0 != 1) begin
            errors++; $display("FAIL cached_pulses got rkey=%0d load=%0d required 0 1", n_rkey - k0, n_load - l0);
        end
        checks++;
        if (t_resp - t_load != 7) begin
            errors++; $display("FAIL cached_latency got %0d required 7", t_resp - t_load);
        end
    endtask

    task automatic test_round_robin();
        int order[3];
        int g, n0, k0;
        logic [127:0] d0, d1, d2;
        exp_t e;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        k0 = n_rkey;
        d0 = {$urandom, $urandom, $urandom, $urandom};
        d1 = {$urandom, $urandom, $urandom, $urandom};
        d2 = {$urandom, $urandom, $urandom, $urandom};
        order[0] = -1; order[1] = -1; order[2] = -1;
        g = 0; n0 = 0;
        bus.req_enc_i = 2'b11;
        bus.req_key_i = {K2, K1};
        bus.req_data_i = {d1, d0};
        bus.req_valid_i = 2'b11;
        for (int c = 0; c < 600 && g < 3; c++) begin
            #1;
            if (bus.req_ready_o[0]) begin
                order[g] = 0; g++;
                e.id = 1'b0; e.err = 1'b0; e.data = core_f(K1, 1'b1, (n0 == 0) ? d0 : d2);
                sb.push_back(e);
                $display("req id=0 enc=1 key=%h data=%h", K1, (n0 == 0) ? d0 : d2);
                @(posedge clk); #1;
                n0++;
                if (n0 == 1) bus.req_data_i[127:0] = d2;
                else bus.req_valid_i[0] = 1'b0;
                @(negedge clk);
            end else if (bus.req_ready_o[1]) begin
                order[g] = 1; g++;
                e.id = 1'b1; e.err = 1'b0; e.data = core_f(K2, 1'b1, d1);
                sb.push_back(e);
                $display("req id=1 enc=1 key=%h data=%h", K2, d1);
                @(posedge clk); #1;
                bus.req_valid_i[1] = 1'b0;
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
        end
        bus.req_valid_i = 2'b00;
        checks++;
        if (order[0] !== 0 || order[1] !== 1 || order[2] !== 0) begin
            errors++; $display("FAIL rr_order got %0d,%0d,%0d required 0,1,0", order[0], order[1], order[2]);
        end
        wait_drain("rr");
        checks++;
        if (n_rkey - k0 != 3) begin
            errors++; $display("FAIL rr_key_reloads got %0d required 3", n_rkey - k0);
        end
    endtask

    task automatic test_timeout();
        int k0;
        hang = 1'b1;
        do_req(1'b1, 1'b1, K1, PT, 1'b1, 1'b1);
        wait_drain("timeout");
        checks++;
        if (t_resp - t_load != 33) begin
            errors++; $display("FAIL timeout_latency got %0d required 33", t_resp - t_load);
        end
        hang = 1'b0;
        k0 = n_rkey;
        do_req(1'b1, 1'b1, K1, CT, 1'b0, 1'b1);
        wait_drain("after_timeout");
        checks++;
        if (n_rkey - k0 != 1) begin
            errors++; $display("FAIL timeout_key_reload got %0d required 1", n_rkey - k0);
        end
    endtask

    task automatic test_reset_mid_op();
        int l0, k0;
        logic seen;
        hang = 1'b1;
        l0 = n_load; seen = 1'b0;
        do_req(1'b0, 1'b1, K1, PT, 1'b0, 1'b0);
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk); #1;
            if (n_load != l0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL midrst_no_load got no aes_load_data required one");
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({bus.resp_valid_o, bus.aes_reset_key_o, bus.aes_load_data_o, bus.aes_enc_or_dec_o} !== 4'b0000 ||
            bus.aes_plain_text_o !== 128'h0 || bus.aes_cipher_key_o !== 128'h0 || bus.req_ready_o !== 2'b00) begin
            errors++; $display("FAIL midrst_outputs got v=%0d rk=%0d ld=%0d enc=%0d text=%h required zeros",
                               bus.resp_valid_o, bus.aes_reset_key_o, bus.aes_load_data_o,
                               bus.aes_enc_or_dec_o, bus.aes_plain_text_o);
        end
        rst_n = 1'b1;
        hang = 1'b0;
        k0 = n_rkey;
        do_req(1'b0, 1'b1, K1, PT, 1'b0, 1'b1);
        wait_drain("midrst");
        checks++;
        if (n_rkey - k0 != 1) begin
            errors++; $display("FAIL midrst_key_reload got %0d required 1", n_rkey - k0);
        end
    endtask

    task automatic test_resp_stall();
        logic seen;
        logic [127:0] cap_data;
        logic cap_id;
        ack_en = 1'b0;
        do_req(1'b1, 1'b0, K1, PT, 1'b0, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk); #1;
            if (bus.resp_valid_o) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL stall_no_resp got resp_valid=0 required 1");
        end
        cap_data = bus.resp_data_o;
        cap_id = bus.resp_id_o;
        bus.req_valid_i = 2'b11;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++;
            if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== cap_data ||
                bus.resp_id_o !== cap_id || bus.req_ready_o !== 2'b00) begin
                errors++; $display("FAIL stall_hold cyc=%0d got v=%0d id=%0d data=%h rdy=%b required v=1 id=%0d data=%h rdy=00",
                                   c, bus.resp_valid_o, bus.resp_id_o, bus.resp_data_o, bus.req_ready_o, cap_id, cap_data);
            end
        end
        bus.req_valid_i = 2'b00;
        ack_en = 1'b1;
        wait_drain("stall");
    endtask

    initial begin
        bus.req_valid_i = '0;
        bus.req_enc_i   = '0;
        bus.req_key_i   = '0;
        bus.req_data_i  = '0;
        test_reset();
        test_encrypt();
        test_cached_decrypt();
        test_round_robin();
        test_timeout();
        test_reset_mid_op();
        test_resp_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
